shift_issue: RTL and testbench

//   Issue stage directly upstream of the five-stage barrel shifter chain
//   (shift1/2/4/8/16). Accepts shift requests with a valid/ready handshake
//   and buffers them in a 2-entry skid FIFO. Decodes the shift count into
//   per-stage shift enables. Presents op, data and carry-in to the first stage.

---
 rtl/shift_issue.sv | 138 +++++++++++++
 tb/tb_shift_issue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// Issue stage ahead of the shift1..shift16 barrel chain: a two-entry skid FIFO
// whose entries carry the shift count already decoded into per-stage enables.
module shift_issue #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [COUNT_WIDTH-1:0] in_count,
    input  logic [31:0]            in_data,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_op,
    output logic [4:0]             out_shift,
    output logic [31:0]            out_data,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_illegal
);

    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        SAR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6
    } shiftOpSel;

    logic [4:0]  mcount;
    logic [4:0]  dec_shift;
    logic        dec_zero;
    logic        dec_illegal;

    logic [2:0]  ent_op      [2];
    logic [4:0]  ent_shift   [2];
    logic [31:0] ent_data    [2];
    logic        ent_carry   [2];
    logic        ent_zero    [2];
    logic        ent_illegal [2];

    logic        head;
    logic        tail;
    logic [1:0]  occupancy;
    logic [1:0]  occupancy_next;
    logic        push;
    logic        pop;

    // Count bits above 4 are masked off, matching x86 shift semantics.
    generate
        if (COUNT_WIDTH > 5) begin : g_count_hi
            logic unused_count_hi;
            assign unused_count_hi = ^in_count[COUNT_WIDTH-1:5];
        end
    endgenerate

    always_comb begin
        mcount      = in_count[4:0];
        dec_zero    = (mcount == 5'd0);
        dec_illegal = 1'b1;
        case (in_op)
            SHL, SHR, SAR, ROL, ROR, RCL, RCR: dec_illegal = 1'b0;
            default:                           dec_illegal = 1'b1;
        endcase
        dec_shift   = dec_illegal ? 5'd0 : mcount;
    end

    // flush overrides both handshakes so neither a push nor a pop lands that edge.
    always_comb begin
        push           = in_valid & in_ready & ~flush;
        pop            = out_valid & out_ready & ~flush;
        occupancy_next = occupancy;
        if (flush) begin
            occupancy_next = 2'd0;
        end else if (push & ~pop) begin
            occupancy_next = occupancy + 2'd1;
        end else if (pop & ~push) begin
            occupancy_next = occupancy - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= 2'd0;
            head      <= 1'b0;
            tail      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            occupancy <= occupancy_next;
            in_ready  <= (occupancy_next != 2'd2);
            if (flush) begin
                head <= 1'b0;
                tail <= 1'b0;
            end else begin
                if (push) begin
                    tail <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                ent_op[i]      <= SHL;
                ent_shift[i]   <= 5'd0;
                ent_data[i]    <= 32'd0;
                ent_carry[i]   <= 1'b0;
                ent_zero[i]    <= 1'b1;
                ent_illegal[i] <= 1'b0;
            end
        end else if (push) begin
            ent_op[tail]      <= in_op;
            ent_shift[tail]   <= dec_shift;
            ent_data[tail]    <= in_data;
            ent_carry[tail]   <= in_carry;
            ent_zero[tail]    <= dec_zero;
            ent_illegal[tail] <= dec_illegal;
        end
    end

    assign out_valid   = (occupancy != 2'd0);
    assign out_op      = ent_op[head];
    assign out_shift   = ent_shift[head];
    assign out_data    = ent_data[head];
    assign out_carry   = ent_carry[head];
    assign out_zero    = ent_zero[head];
    assign out_illegal = ent_illegal[head];

endmodule

// File: tb/tb_shift_issue.sv
// Scoreboard bench for shift_issue: accepted requests are decoded by a small
// model into a queue and compared in order as the DUT hands them downstream.
module tb_shift_issue;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_RCL = 3'd5;
    localparam logic [2:0] OP_RCR = 3'd6;
    localparam logic [2:0] OP_BAD = 3'd7;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_count;
    logic [31:0] in_data;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [4:0]  out_shift;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_illegal;

    int          checkCount = 0;
    int          errorCount = 0;
    int          modelCount = 0;
    int          popCount   = 0;
    int          popMark    = 0;
    logic [42:0] sbQueue [$];

    shift_issue #(.COUNT_WIDTH(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_count    (in_count),
        .in_data     (in_data),
        .in_carry    (in_carry),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_shift   (out_shift),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [42:0] expectOf(input logic [2:0] op, input logic [7:0] cnt,
                                             input logic [31:0] data, input logic carry);
        logic [4:0] m;
        logic       bad;
        m   = cnt[4:0];
        bad = (op == OP_BAD);
        return {op, (bad ? 5'd0 : m), data, carry, (m == 5'd0), bad};
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [7:0] cnt,
                                 input logic [31:0] data, input logic c,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_op     = op;
        in_count  = cnt;
        in_data   = data;
        in_carry  = c;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so at negedge they are the values the next edge sees.
    always @(negedge clk) begin
        if (!reset_n) begin
            sbQueue.delete();
            modelCount = 0;
        end else begin
            checkOutput("in_ready", 64'(in_ready), 64'(modelCount != 2));
            checkOutput("out_valid", 64'(out_valid), 64'(modelCount != 0));
            if (flush) begin
                sbQueue.delete();
                modelCount = 0;
            end else begin
                if (out_valid && out_ready) begin
                    popCount++;
                    checkOutput("pop_nonempty", 64'(sbQueue.size() != 0), 64'd1);
                    if (sbQueue.size() != 0) begin
                        checkOutput("payload",
                                    64'({out_op, out_shift, out_data, out_carry, out_zero, out_illegal}),
                                    64'(sbQueue.pop_front()));
                    end
                end
                if (in_valid && in_ready) begin
                    sbQueue.push_back(expectOf(in_op, in_count, in_data, in_carry));
                end
                if (modelCount != 0 && out_ready) begin
                    modelCount = modelCount - 1;
                end
                if (in_valid && (modelCount + ((modelCount != 0 && out_ready) ? 1 : 0)) != 2) begin
                    modelCount = modelCount + 1;
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_SHL;
        in_count  = 8'h00;
        in_data   = 32'h0;
        in_carry  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_payload",
                    64'({out_op, out_shift, out_data, out_carry, out_zero, out_illegal}),
                    64'({OP_SHL, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0}));
        reset_n = 1'b1;

        // Basic push: visible the cycle after the accepting edge.
        applyStimulus(1, OP_SHL, 8'h05, 32'h0000_0001, 0, 0, 0);
        checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_out_shift", 64'(out_shift), 64'h05);
        checkOutput("t1_out_zero", 64'(out_zero), 64'd0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        // Count masking.
        applyStimulus(1, OP_SHR, 8'h20, 32'hDEAD_BEEF, 1, 1, 0);
        checkOutput("t2_shift_masked", 64'(out_shift), 64'h00);
        checkOutput("t2_zero_masked", 64'(out_zero), 64'd1);
        applyStimulus(1, OP_SAR, 8'hFF, 32'h8000_0000, 0, 1, 0);
        checkOutput("t2_shift_ff", 64'(out_shift), 64'h1F);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        // Back-pressure: A and B fill the FIFO, C waits for space.
        applyStimulus(1, OP_ROL, 8'h01, 32'hAAAA_0001, 0, 0, 0);
        applyStimulus(1, OP_ROR, 8'h02, 32'hBBBB_0002, 1, 0, 0);
        checkOutput("t3_full_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, OP_RCL, 8'h03, 32'hCCCC_0003, 1, 0, 0);
        checkOutput("t3_hold_data", 64'(out_data), 64'hAAAA_0001);
        applyStimulus(1, OP_RCL, 8'h03, 32'hCCCC_0003, 1, 0, 0);
        applyStimulus(1, OP_RCL, 8'h03, 32'hCCCC_0003, 1, 1, 0);
        applyStimulus(1, OP_RCL, 8'h03, 32'hCCCC_0003, 1, 1, 0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        // Steady state at occupancy 1: one push and one pop every cycle.
        applyStimulus(1, OP_SHL, 8'h10, 32'h1234_5678, 0, 0, 0);
        popMark = popCount;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 3'(i % 7), 8'($urandom_range(0, 255)), $urandom, 1'($urandom_range(0, 1)), 1, 0);
        end
        checkOutput("t4_throughput", 64'(popCount - popMark), 64'd10);
        checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        // flush beats a concurrent push, from full and from half-full.
        applyStimulus(1, OP_SHL, 8'h04, 32'h0F0F_0F0F, 0, 0, 0);
        applyStimulus(1, OP_SHR, 8'h08, 32'hF0F0_F0F0, 0, 0, 0);
        applyStimulus(1, OP_SAR, 8'h09, 32'h5555_5555, 0, 1, 1);
        checkOutput("t5_flush_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_flush_ready", 64'(in_ready), 64'd1);
        applyStimulus(1, OP_ROR, 8'h0C, 32'h0000_00D0, 1, 0, 0);
        applyStimulus(1, OP_ROL, 8'h0D, 32'h0000_00E0, 0, 1, 1);
        checkOutput("t5_flush1_valid", 64'(out_valid), 64'd0);
        applyStimulus(1, OP_RCR, 8'h11, 32'h0000_00F0, 0, 0, 0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        // Asynchronous reset in the middle of a cycle with the FIFO full.
        applyStimulus(1, OP_SHL, 8'h06, 32'h1111_1111, 0, 0, 0);
        applyStimulus(1, OP_SHR, 8'h07, 32'h2222_2222, 1, 0, 0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_rst_ready", 64'(in_ready), 64'd1);
        checkOutput("t6_rst_zero", 64'(out_zero), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Illegal opcode travels through with its stage enables cleared.
        applyStimulus(1, OP_BAD, 8'h07, 32'h7777_7777, 1, 0, 0);
        checkOutput("t6_illegal", 64'(out_illegal), 64'd1);
        checkOutput("t6_illegal_shift", 64'(out_shift), 64'd0);
        applyStimulus(1, OP_RCR, 8'hE3, 32'h3333_3333, 1, 1, 0);
        checkOutput("t6_rcr_shift", 64'(out_shift), 64'h03);
        checkOutput("t6_rcr_legal", 64'(out_illegal), 64'd0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);
        applyStimulus(0, OP_SHL, 8'h00, 32'h0, 0, 1, 0);

        checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
